imm_control_sequencer: RTL and testbench

- Parametrised hardware control sequencer that replaces hand-written bench FSMs for the bus datapath.
- Runs instruction fetch (T0–T2), then decodes and executes immediate-class ALU instructions (addi, andi, ori) plus nop and halt.
- Generalised in opcode width and retire-counter width; adds a memory-ready handshake, run/stop control, illegal-opcode trap and retire counter.
- Sits beside the datapath and drives its control strobes directly.

---
 rtl/imm_control_sequencer_if.sv | 33 +++
 rtl/imm_control_sequencer.sv | 158 +++++++++++++++
 tb/tb_imm_control_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_control_sequencer_if.sv
// Control/status bundle between imm_control_sequencer and the bus datapath.
// The sequencer takes the master side; the datapath (or a bench) takes the slave side.
interface imm_control_sequencer_if #(
    parameter int unsigned BITS = 32,
    parameter int unsigned CNTW = 16
);
    logic            run_in;
    logic [BITS-1:0] ir_val;
    logic            mem_done;

    logic PCout, MARin, IncPC, RZin, RZout, PCin, Read, MDRin, MDRout, IRin;
    logic Grb, Rout, RYin, Cout, Gra, Rin;
    logic ADD, AND, OR;

    logic            busy;
    logic            halted;
    logic            illegal;
    logic [CNTW-1:0] instr_count;

    modport master (
        input  run_in, ir_val, mem_done,
        output PCout, MARin, IncPC, RZin, RZout, PCin, Read, MDRin, MDRout, IRin,
        output Grb, Rout, RYin, Cout, Gra, Rin, ADD, AND, OR,
        output busy, halted, illegal, instr_count
    );

    modport slave (
        output run_in, ir_val, mem_done,
        input  PCout, MARin, IncPC, RZin, RZout, PCin, Read, MDRin, MDRout, IRin,
        input  Grb, Rout, RYin, Cout, Gra, Rin, ADD, AND, OR,
        input  busy, halted, illegal, instr_count
    );
endinterface

// File: rtl/imm_control_sequencer.sv
// Fetch/decode/execute sequencer for immediate ALU ops (addi/andi/ori), nop and halt.
// Moore strobes decoded from state; only T3 looks at the live IR opcode.
module imm_control_sequencer #(
    parameter int unsigned    BITS    = 32,
    parameter int unsigned    OPW     = 5,
    parameter logic [OPW-1:0] OP_ADDI = 5'b01100,
    parameter logic [OPW-1:0] OP_ANDI = 5'b01101,
    parameter logic [OPW-1:0] OP_ORI  = 5'b01110,
    parameter logic [OPW-1:0] OP_NOP  = 5'b11010,
    parameter logic [OPW-1:0] OP_HALT = 5'b11011,
    parameter int unsigned    CNTW    = 16
) (
    input logic                  clk,
    input logic                  reset,
    imm_control_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StHalted
    } state_e;

    state_e          state_q, state_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            illegal_q, illegal_d;
    logic            first_t1_q, first_t1_d;

    logic [OPW-1:0]  op_live;
    logic            live_is_alu;
    logic            unused_ir;

    assign op_live     = bus.ir_val[BITS-1 -: OPW];
    assign live_is_alu = (op_live == OP_ADDI) || (op_live == OP_ANDI) || (op_live == OP_ORI);
    assign unused_ir   = ^bus.ir_val[BITS-OPW-1:0];

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        illegal_d  = illegal_q;
        first_t1_d = first_t1_q;
        unique case (state_q)
            StIdle: if (bus.run_in) state_d = StT0;
            StT0: begin
                state_d    = StT1;
                first_t1_d = 1'b1;
            end
            StT1: begin
                first_t1_d = 1'b0;
                if (bus.mem_done) state_d = StT2;
            end
            StT2: state_d = StT3;
            StT3: begin
                op_d = op_live;
                if (live_is_alu) begin
                    state_d = StT4;
                end else if (op_live == OP_NOP) begin
                    cnt_d   = cnt_q + CNTW'(1);
                    state_d = bus.run_in ? StT0 : StIdle;
                end else if (op_live == OP_HALT) begin
                    cnt_d   = cnt_q + CNTW'(1);
                    state_d = StHalted;
                end else begin
                    // Undefined opcode traps without retiring.
                    illegal_d = 1'b1;
                    state_d   = StHalted;
                end
            end
            StT4: state_d = StT5;
            StT5: begin
                cnt_d   = cnt_q + CNTW'(1);
                state_d = bus.run_in ? StT0 : StIdle;
            end
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            op_q       <= '0;
            cnt_q      <= '0;
            illegal_q  <= 1'b0;
            first_t1_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            illegal_q  <= illegal_d;
            first_t1_q <= first_t1_d;
        end
    end

    always_comb begin
        bus.PCout  = 1'b0;
        bus.MARin  = 1'b0;
        bus.IncPC  = 1'b0;
        bus.RZin   = 1'b0;
        bus.RZout  = 1'b0;
        bus.PCin   = 1'b0;
        bus.Read   = 1'b0;
        bus.MDRin  = 1'b0;
        bus.MDRout = 1'b0;
        bus.IRin   = 1'b0;
        bus.Grb    = 1'b0;
        bus.Rout   = 1'b0;
        bus.RYin   = 1'b0;
        bus.Cout   = 1'b0;
        bus.Gra    = 1'b0;
        bus.Rin    = 1'b0;
        bus.ADD    = 1'b0;
        bus.AND    = 1'b0;
        bus.OR     = 1'b0;
        unique case (state_q)
            StT0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.RZin  = 1'b1;
            end
            StT1: begin
                bus.RZout = 1'b1;
                bus.Read  = 1'b1;
                bus.MDRin = 1'b1;
                bus.PCin  = first_t1_q;
            end
            StT2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            StT3: begin
                bus.Grb  = live_is_alu;
                bus.Rout = live_is_alu;
                bus.RYin = live_is_alu;
            end
            StT4: begin
                bus.Cout = 1'b1;
                bus.RZin = 1'b1;
                bus.ADD  = (op_q == OP_ADDI);
                bus.AND  = (op_q == OP_ANDI);
                bus.OR   = (op_q == OP_ORI);
            end
            StT5: begin
                bus.RZout = 1'b1;
                bus.Gra   = 1'b1;
                bus.Rin   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy        = (state_q != StIdle) && (state_q != StHalted);
    assign bus.halted      = (state_q == StHalted);
    assign bus.illegal     = illegal_q;
    assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_imm_control_sequencer.sv
// Randomised bench for imm_control_sequencer: per-instruction expected strobe schedules
// built from the instruction's opcode and memory stall length, plus a retire-count model.
module tb_imm_control_sequencer;

    localparam int unsigned CW = 8;

    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Strobe word order: PCout MARin IncPC RZin RZout PCin Read MDRin MDRout IRin
    //                    Grb Rout RYin Cout Gra Rin ADD AND OR
    localparam logic [18:0] W_T0  = 19'h78000;
    localparam logic [18:0] W_T1F = 19'h07800;
    localparam logic [18:0] W_T1  = 19'h05800;
    localparam logic [18:0] W_T2  = 19'h00600;
    localparam logic [18:0] W_T3A = 19'h001C0;
    localparam logic [18:0] W_T4  = 19'h08020;
    localparam logic [18:0] W_T5  = 19'h04018;

    logic clk;
    logic rst_n;

    imm_control_sequencer_if #(.BITS(32), .CNTW(CW)) bus ();

    imm_control_sequencer #(.BITS(32), .CNTW(CW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [18:0] strobes;
    assign strobes = {bus.PCout, bus.MARin, bus.IncPC, bus.RZin, bus.RZout, bus.PCin, bus.Read,
                      bus.MDRin, bus.MDRout, bus.IRin, bus.Grb, bus.Rout, bus.RYin, bus.Cout,
                      bus.Gra, bus.Rin, bus.ADD, bus.AND, bus.OR};

    int          vecs;
    int          misc;
    int unsigned model_cnt;
    bit          model_halted;
    bit          model_illegal;

    // Runs one instruction from its T0 cycle; DUT must be about to show T0 at the next negedge.
    task automatic exec_instr(input string tag, input logic [4:0] op, input int stalls,
                              input bit drop_t2);
        logic [18:0] exp_q[$];
        bit          md_q[$];
        int          t2_idx;
        bit          is_alu;
        bit          retires;
        bit          to_halt;
        logic [18:0] alu_bit;
        logic [CW+2:0] got_post;
        logic [CW+2:0] exp_post;

        is_alu  = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
        retires = is_alu || (op == OP_NOP) || (op == OP_HALT);
        to_halt = !is_alu && (op != OP_NOP);
        alu_bit = (op == OP_ADDI) ? 19'h4 : (op == OP_ANDI) ? 19'h2 : 19'h1;

        bus.ir_val = {op, 27'($urandom)};

        exp_q.push_back(W_T0);
        md_q.push_back(1'($urandom));
        for (int s = 0; s <= stalls; s++) begin
            exp_q.push_back((s == 0) ? W_T1F : W_T1);
            md_q.push_back(s == stalls);
        end
        exp_q.push_back(W_T2);
        md_q.push_back(1'($urandom));
        t2_idx = exp_q.size() - 1;
        exp_q.push_back(is_alu ? W_T3A : 19'h0);
        md_q.push_back(1'($urandom));
        if (is_alu) begin
            exp_q.push_back(W_T4 | alu_bit);
            md_q.push_back(1'($urandom));
            exp_q.push_back(W_T5);
            md_q.push_back(1'($urandom));
        end

        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            vecs++;
            if ({strobes, bus.busy, bus.halted} !== {exp_q[i], 2'b10}) begin
                misc++;
                $display("FAIL %s op=%b cycle %0d: strobes/busy/halted got %h want %h",
                         tag, op, i, {strobes, bus.busy, bus.halted}, {exp_q[i], 2'b10});
            end
            bus.mem_done = md_q[i];
            if (drop_t2 && i == t2_idx) bus.run_in = 1'b0;
        end

        @(posedge clk);
        #1;
        if (retires) model_cnt = (model_cnt + 1) % (1 << CW);
        if (to_halt) model_halted = 1'b1;
        if (!retires) model_illegal = 1'b1;
        exp_post = {CW'(model_cnt), model_illegal, model_halted,
                    !model_halted && bus.run_in};
        got_post = {bus.instr_count, bus.illegal, bus.halted, bus.busy};
        vecs++;
        if (got_post !== exp_post) begin
            misc++;
            $display("FAIL %s op=%b retire: count/illegal/halted/busy got %h want %h",
                     tag, op, got_post, exp_post);
        end
    endtask

    task automatic start_from_idle(input string tag);
        @(negedge clk);
        vecs++;
        if ({strobes, bus.busy, bus.halted} !== 21'h0) begin
            misc++;
            $display("FAIL %s idle: strobes/busy/halted got %h want 0", tag,
                     {strobes, bus.busy, bus.halted});
        end
        bus.run_in = 1'b1;
    endtask

    task automatic test_reset();
        bus.run_in   = 1'b0;
        bus.mem_done = 1'b0;
        rst_n        = 1'b0;
        #1;
        model_cnt     = 0;
        model_halted  = 1'b0;
        model_illegal = 1'b0;
        repeat (2) @(negedge clk);
        vecs++;
        if ({strobes, bus.busy, bus.halted, bus.illegal, bus.instr_count} !== '0) begin
            misc++;
            $display("FAIL reset: outputs got %h want 0",
                     {strobes, bus.busy, bus.halted, bus.illegal, bus.instr_count});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        start_from_idle("addi");
        exec_instr("addi", OP_ADDI, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        exec_instr("b2b_andi", OP_ANDI, 0, 1'b0);
        exec_instr("b2b_ori", OP_ORI, 0, 1'b0);
    endtask

    task automatic test_stall();
        exec_instr("stall3", OP_ADDI, 3, 1'b0);
    endtask

    task automatic test_random();
        logic [4:0] ops[4];
        ops[0] = OP_ADDI;
        ops[1] = OP_ANDI;
        ops[2] = OP_ORI;
        ops[3] = OP_NOP;
        for (int n = 0; n < 10; n++)
            exec_instr("random", ops[$urandom_range(0, 3)], $urandom_range(0, 3), 1'b0);
    endtask

    task automatic test_run_drop();
        exec_instr("run_drop", OP_ADDI, $urandom_range(0, 2), 1'b1);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            vecs++;
            if ({strobes, bus.busy, bus.halted} !== 21'h0) begin
                misc++;
                $display("FAIL run_drop idle %0d: strobes/busy/halted got %h want 0", n,
                         {strobes, bus.busy, bus.halted});
            end
            bus.mem_done = 1'($urandom);
        end
    endtask

    task automatic test_wrap();
        bit wrapped;
        wrapped = 1'b0;
        start_from_idle("wrap");
        for (int n = 0; n < 300 && !wrapped; n++) begin
            exec_instr("wrap_nop", OP_NOP, 0, 1'b0);
            if (model_cnt == 0) wrapped = 1'b1;
        end
        vecs++;
        if (bus.instr_count !== CW'(0)) begin
            misc++;
            $display("FAIL wrap: count got %h want 0", bus.instr_count);
        end
    endtask

    task automatic test_halt();
        exec_instr("halt", OP_HALT, 1, 1'b0);
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            vecs++;
            if ({strobes, bus.busy, bus.halted, bus.illegal, bus.instr_count} !==
                {19'h0, 2'b01, 1'b0, CW'(model_cnt)}) begin
                misc++;
                $display("FAIL halt hold %0d: got %h want %h", n,
                         {strobes, bus.busy, bus.halted, bus.illegal, bus.instr_count},
                         {19'h0, 2'b01, 1'b0, CW'(model_cnt)});
            end
            bus.run_in   = 1'($urandom);
            bus.mem_done = 1'($urandom);
        end
    endtask

    task automatic test_illegal();
        test_reset();
        start_from_idle("illegal");
        exec_instr("pre_illegal", OP_ORI, 0, 1'b0);
        exec_instr("illegal", 5'($urandom_range(0, 11)), $urandom_range(0, 2), 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({strobes, bus.busy, bus.halted, bus.illegal, bus.instr_count} !== '0) begin
            misc++;
            $display("FAIL async_reset: outputs got %h want 0",
                     {strobes, bus.busy, bus.halted, bus.illegal, bus.instr_count});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs         = 0;
        misc         = 0;
        rst_n        = 1'b0;
        bus.run_in   = 1'b0;
        bus.mem_done = 1'b0;
        bus.ir_val   = '0;
        test_reset();
        test_addi();
        test_back_to_back();
        test_stall();
        test_random();
        test_run_drop();
        test_wrap();
        test_halt();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, misc);
        $finish;
    end

endmodule
